// File: rtl/desorb_sequencer.sv
// Heater profile sequencer: PREHEAT -> DESORB -> COOL repeated N times, phase and duty ref to the PWM stage.
// Outputs are registered one edge after the triggering input; no backpressure, start is ignored while busy.
module desorb_sequencer #(
    parameter int PRESCALE      = 1000,
    parameter int PREHEAT_TICKS = 50,
    parameter int DESORB_TICKS  = 200,
    parameter int COOL_TICKS    = 100,
    parameter int CNT_W         = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [1:0] level_i,
    input  logic [3:0] cycles_i,
    output logic [1:0] state_bits_o,
    output logic [1:0] ref_bits_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] cycles_left_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PREHEAT = 2'b01,
        DESORB  = 2'b10,
        COOL    = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [1:0]       level_q, level_d;
    logic [3:0]       left_q, left_d;
    logic             aborted_q, aborted_d;
    logic             done_q, done_d;
    logic [1:0]       ref_q, ref_d;
    logic             busy_q;
    logic             tick;
    logic             enter;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        left_d    = left_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        enter     = 1'b0;
        pre_d     = pre_q;
        tick_d    = tick_q;
        ref_d     = 2'b00;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = PREHEAT;
                    level_d   = level_i;
                    left_d    = (cycles_i == 4'd0) ? 4'd1 : cycles_i;
                    aborted_d = 1'b0;
                    enter     = 1'b1;
                end
            end
            PREHEAT: begin
                if (abort_i) begin
                    state_d   = COOL;
                    left_d    = 4'd1;
                    aborted_d = 1'b1;
                    enter     = 1'b1;
                end else if (tick && tick_q == CNT_W'(PREHEAT_TICKS - 1)) begin
                    state_d = DESORB;
                    enter   = 1'b1;
                end
            end
            DESORB: begin
                if (abort_i) begin
                    state_d   = COOL;
                    left_d    = 4'd1;
                    aborted_d = 1'b1;
                    enter     = 1'b1;
                end else if (tick && tick_q == CNT_W'(DESORB_TICKS - 1)) begin
                    state_d = COOL;
                    enter   = 1'b1;
                end
            end
            COOL: begin
                // Abort is deliberately not honoured here: COOL always runs to completion.
                if (tick && tick_q == CNT_W'(COOL_TICKS - 1)) begin
                    enter = 1'b1;
                    if (left_q > 4'd1) begin
                        state_d = PREHEAT;
                        left_d  = left_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        left_d  = 4'd0;
                        done_d  = ~aborted_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter || state_d == IDLE) begin
            pre_d  = '0;
            tick_d = '0;
        end else if (tick) begin
            pre_d  = '0;
            tick_d = tick_q + CNT_W'(1);
        end else begin
            pre_d  = pre_q + PW'(1);
        end

        case (state_d)
            PREHEAT: ref_d = 2'b11;
            DESORB:  ref_d = level_d;
            COOL:    ref_d = 2'b01;
            default: ref_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            tick_q    <= '0;
            level_q   <= 2'b00;
            left_q    <= 4'd0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            ref_q     <= 2'b00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            left_q    <= left_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
            ref_q     <= ref_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign state_bits_o  = state_q;
    assign ref_bits_o    = ref_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycles_left_o = left_q;

endmodule

// File: tb/tb_desorb_sequencer.sv
// Bench for desorb_sequencer with a cycle-offset reference model of the heater profile.
module tb_desorb_sequencer;
    localparam int PRESCALE      = 4;
    localparam int PREHEAT_TICKS = 2;
    localparam int DESORB_TICKS  = 3;
    localparam int COOL_TICKS    = 2;
    localparam int PH_LEN = PREHEAT_TICKS * PRESCALE;
    localparam int DS_LEN = DESORB_TICKS * PRESCALE;
    localparam int CL_LEN = COOL_TICKS * PRESCALE;
    localparam int PROF   = PH_LEN + DS_LEN + CL_LEN;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic [1:0] level_i;
    logic [3:0] cycles_i;
    logic [1:0] state_bits_o;
    logic [1:0] ref_bits_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] cycles_left_o;

    int total = 0;
    int bad   = 0;

    desorb_sequencer #(
        .PRESCALE(PRESCALE),
        .PREHEAT_TICKS(PREHEAT_TICKS),
        .DESORB_TICKS(DESORB_TICKS),
        .COOL_TICKS(COOL_TICKS),
        .CNT_W(16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .abort_i(abort_i),
        .level_i(level_i),
        .cycles_i(cycles_i),
        .state_bits_o(state_bits_o),
        .ref_bits_o(ref_bits_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .cycles_left_o(cycles_left_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected {state, ref, busy, done, cycles_left} t cycles after the accepting start edge.
    function automatic logic [9:0] model(input int t, input logic [3:0] n, input int ab, input logic [1:0] lvl);
        int nn, o, left;
        logic [1:0] st, rf;
        logic dn;
        bit ab_ok;
        nn    = (n == 4'd0) ? 1 : int'(n);
        ab_ok = (ab >= 0) && (ab < nn * PROF) && ((ab % PROF) < PH_LEN + DS_LEN);
        dn    = 1'b0;
        if (ab_ok && t > ab) begin
            if (t <= ab + CL_LEN) begin st = 2'b11; left = 1; end
            else begin st = 2'b00; left = 0; end
        end else if (t < nn * PROF) begin
            o    = t % PROF;
            left = nn - t / PROF;
            st   = (o < PH_LEN) ? 2'b01 : (o < PH_LEN + DS_LEN) ? 2'b10 : 2'b11;
        end else begin
            st   = 2'b00;
            left = 0;
            dn   = (t == nn * PROF);
        end
        case (st)
            2'b01:   rf = 2'b11;
            2'b10:   rf = lvl;
            2'b11:   rf = 2'b01;
            default: rf = 2'b00;
        endcase
        return {st, rf, (st != 2'b00), dn, 4'(left)};
    endfunction

    task automatic chk(input string tag, input int t, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed st/ref/busy/done/left=%b required=%b", tag, t, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {state_bits_o, ref_bits_o, busy_o, done_o, cycles_left_o};
    endfunction

    // Called at a negedge; issues start for the next edge and checks every following cycle.
    task automatic run(input string tag, input logic [1:0] lvl, input logic [3:0] n, input int ab,
                       input int glitch, input bit start_abort, input int len);
        start_i  = 1'b1;
        level_i  = lvl;
        cycles_i = n;
        abort_i  = start_abort;
        for (int t = 0; t < len; t++) begin
            @(negedge clk_i);
            chk(tag, t, outs(), model(t, n, ab, lvl));
            start_i = (t == glitch);
            abort_i = (t == ab);
            if (t == glitch) level_i = ~lvl;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin
        logic [3:0] rn;
        int rab;
        rst_i    = 1'b1;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        level_i  = 2'b00;
        cycles_i = 4'd0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("idle", i, outs(), 10'b0);
        end

        run("single", 2'b10, 4'd1, -1, -1, 1'b0, PROF + 3);
        run("three", 2'b01, 4'd3, -1, -1, 1'b0, 3 * PROF + 3);
        run("abort_desorb", 2'b11, 4'd3, 10, -1, 1'b0, PROF + 3);
        run("start_in_desorb", 2'b10, 4'd1, -1, 12, 1'b0, PROF + 3);
        run("zero_cycles", 2'b01, 4'd0, -1, -1, 1'b0, PROF + 3);
        run("abort_last_preheat", 2'b10, 4'd2, PH_LEN - 1, -1, 1'b0, PROF + 3);
        run("abort_on_desorb_exit", 2'b11, 4'd3, PROF + PH_LEN + DS_LEN - 1, -1, 1'b0, 2 * PROF + 3);
        run("abort_in_cool", 2'b01, 4'd1, PH_LEN + DS_LEN, -1, 1'b0, PROF + 3);
        run("start_with_abort", 2'b10, 4'd1, -1, -1, 1'b1, PROF + 3);

        // Async reset mid-PREHEAT
        start_i  = 1'b1;
        level_i  = 2'b11;
        cycles_i = 4'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_reset", 0, outs(), model(3, 4'd2, -1, 2'b11));
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("async_reset", 0, outs(), 10'b0);
        @(negedge clk_i);
        chk("in_reset", 0, outs(), 10'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("after_reset", 0, outs(), 10'b0);
        run("post_reset", 2'b01, 4'd1, -1, -1, 1'b0, PROF + 3);

        // Random runs
        for (int r = 0; r < 6; r++) begin
            rn  = 4'($urandom_range(0, 3));
            rab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3 * PROF)) : -1;
            run("random", 2'($urandom_range(0, 3)), rn, rab, -1, 1'b0, 3 * PROF + 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
